// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared opcode, funct3, stage and ALU encodings for rv32i_core.
// No ports; imported by rv32i_alu and rv32i_core.
package rv32i_pkg;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_BEQ  = 3'd0;
   localparam logic [2:0] F3_BNE  = 3'd1;
   localparam logic [2:0] F3_BLT  = 3'd4;
   localparam logic [2:0] F3_BGE  = 3'd5;
   localparam logic [2:0] F3_BLTU = 3'd6;
   localparam logic [2:0] F3_BGEU = 3'd7;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   localparam logic [2:0] F3_ADD  = 3'd0;
   localparam logic [2:0] F3_SLL  = 3'd1;
   localparam logic [2:0] F3_SLT  = 3'd2;
   localparam logic [2:0] F3_SLTU = 3'd3;
   localparam logic [2:0] F3_XOR  = 3'd4;
   localparam logic [2:0] F3_SR   = 3'd5;
   localparam logic [2:0] F3_OR   = 3'd6;
   localparam logic [2:0] F3_AND  = 3'd7;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2,
      ST_WB     = 2'd3
   } stage_t;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_t;

   // alt selects SUB for funct3=000 and SRA for funct3=101
   function automatic alu_op_t alu_sel(input logic [2:0] f3, input logic alt);
      case (f3)
         F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  return ALU_SLL;
         F3_SLT:  return ALU_SLT;
         F3_SLTU: return ALU_SLTU;
         F3_XOR:  return ALU_XOR;
         F3_SR:   return alt ? ALU_SRA : ALU_SRL;
         F3_OR:   return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction
endpackage

// File: rtl/rv32i_alu.sv
// rv32i_alu: combinational RV32I ALU with branch compare flags.
// Ports: a, b (operands), alu_op (operation) -> result, eq (a==b),
//        lt (signed a<b), ltu (unsigned a<b).
module rv32i_alu
   import rv32i_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  alu_op_t     alu_op,
   output logic [31:0] result,
   output logic        eq,
   output logic        lt,
   output logic        ltu
);
   assign eq  = a == b;
   assign lt  = $signed(a) < $signed(b);
   assign ltu = a < b;

   always_comb begin
      result = a + b;
      case (alu_op)
         ALU_SUB:  result = a - b;
         ALU_SLL:  result = a << b[4:0];
         ALU_SLT:  result = {31'd0, lt};
         ALU_SLTU: result = {31'd0, ltu};
         ALU_XOR:  result = a ^ b;
         ALU_SRL:  result = a >> b[4:0];
         ALU_SRA:  result = 32'($signed(a) >>> b[4:0]);
         ALU_OR:   result = a | b;
         ALU_AND:  result = a & b;
         default:  result = a + b;
      endcase
   end
endmodule

// File: rtl/rv32i_core.sv
// rv32i_core: four-cycle multi-cycle RV32I core with unified word memory.
// Ports: clk (rising-edge clock), rst (async assert, active-low reset).
// Optional: define CORE_TRACE_EN to print a line at every writeback.
module rv32i_core
   import rv32i_pkg::*;
#(
   parameter int          MEM_WORDS     = 4096,
   parameter string       MEM_INIT_FILE = "program.hex",
   parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
   input logic clk,
   input logic rst
);
   localparam int AW = $clog2(MEM_WORDS);

   logic [31:0] mem  [0:MEM_WORDS-1];
   logic [31:0] regs [0:31];
   logic [31:0] pc, idata, rs1v, rs2v, imm, alu_res, mrd;
   logic [6:0]  opcode;
   stage_t      pstage, stage_nx;
   logic        br_take;

   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic [31:0] imm_nx, alu_a, alu_b, alu_y, ld_val, wb_val, pc_nx, pc_inc, st_data;
   logic [15:0] ld_h;
   logic [7:0]  ld_b;
   logic [3:0]  st_be;
   logic [AW-1:0] d_idx;
   logic        alu_eq, alu_lt, alu_ltu, br_cond, wr_en;
   alu_op_t     alu_op;

   assign opcode = idata[6:0];
   assign rd     = idata[11:7];
   assign f3     = idata[14:12];
   assign rs1    = idata[19:15];
   assign rs2    = idata[24:20];

   assign imm_nx = (opcode == OP_STORE)  ? {{20{idata[31]}}, idata[31:25], idata[11:7]} :
                   (opcode == OP_BRANCH) ? {{19{idata[31]}}, idata[31], idata[7], idata[30:25], idata[11:8], 1'b0} :
                   (opcode == OP_LUI || opcode == OP_AUIPC) ? {idata[31:12], 12'd0} :
                   (opcode == OP_JAL)    ? {{11{idata[31]}}, idata[31], idata[19:12], idata[20], idata[30:21], 1'b0} :
                                           {{20{idata[31]}}, idata[31:20]};

   // JAL computes its target in the ALU; JAL/JALR link values come from pc_inc
   assign alu_a  = (opcode == OP_LUI) ? 32'd0 :
                   (opcode == OP_AUIPC || opcode == OP_JAL) ? pc : rs1v;
   assign alu_b  = (opcode == OP_REG || opcode == OP_BRANCH) ? rs2v : imm;
   // funct7[5] of an I-type ADDI is immediate data, so only shifts honour it
   assign alu_op = (opcode == OP_REG) ? alu_sel(f3, idata[30]) :
                   (opcode == OP_IMM) ? alu_sel(f3, idata[30] && f3 == F3_SR) : ALU_ADD;

   rv32i_alu u_alu (
      .a(alu_a), .b(alu_b), .alu_op(alu_op),
      .result(alu_y), .eq(alu_eq), .lt(alu_lt), .ltu(alu_ltu)
   );

   assign br_cond = (f3 == F3_BEQ)  ? alu_eq  :
                    (f3 == F3_BNE)  ? !alu_eq :
                    (f3 == F3_BLT)  ? alu_lt  :
                    (f3 == F3_BGE)  ? !alu_lt :
                    (f3 == F3_BLTU) ? alu_ltu :
                    (f3 == F3_BGEU) ? !alu_ltu : 1'b0;

   // data accesses use the live ALU address during EXECUTE
   assign d_idx   = alu_y[AW+1:2];
   assign st_be   = (f3 == F3_B) ? 4'b0001 << alu_y[1:0] :
                    (f3 == F3_H) ? (alu_y[1] ? 4'b1100 : 4'b0011) :
                    (f3 == F3_W) ? 4'b1111 : 4'b0000;
   assign st_data = (f3 == F3_B) ? {4{rs2v[7:0]}} :
                    (f3 == F3_H) ? {2{rs2v[15:0]}} : rs2v;

   assign ld_b   = mrd[8*alu_res[1:0] +: 8];
   assign ld_h   = alu_res[1] ? mrd[31:16] : mrd[15:0];
   assign ld_val = (f3 == F3_B)  ? {{24{ld_b[7]}}, ld_b} :
                   (f3 == F3_H)  ? {{16{ld_h[15]}}, ld_h} :
                   (f3 == F3_BU) ? {24'd0, ld_b} :
                   (f3 == F3_HU) ? {16'd0, ld_h} : mrd;

   assign pc_inc = pc + 32'd4;
   assign wr_en  = rd != 5'd0 &&
                   (opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL ||
                    opcode == OP_JALR || opcode == OP_LOAD || opcode == OP_IMM ||
                    opcode == OP_REG);
   assign wb_val = (opcode == OP_JAL || opcode == OP_JALR) ? pc_inc :
                   (opcode == OP_LOAD) ? ld_val : alu_res;
   assign pc_nx  = (opcode == OP_JAL)  ? alu_res :
                   (opcode == OP_JALR) ? {alu_res[31:1], 1'b0} :
                   (opcode == OP_BRANCH && br_take) ? pc + imm : pc_inc;

   always_comb stage_nx = stage_t'(pstage + 2'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         pstage <= ST_FETCH;
      else
         pstage <= stage_nx;
   end

   // memory has no reset; gating on rst drops a store whose edge meets reset
   always_ff @(posedge clk) begin
      if (rst && pstage == ST_EXEC) begin
         if (opcode == OP_STORE)
            for (int k = 0; k < 4; k++)
               if (st_be[k]) mem[d_idx][8*k +: 8] <= st_data[8*k +: 8];
         mrd <= mem[d_idx];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc      <= RESET_PC;
         idata   <= '0;
         rs1v    <= '0;
         rs2v    <= '0;
         imm     <= '0;
         alu_res <= '0;
         br_take <= 1'b0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         case (pstage)
            ST_FETCH: idata <= mem[pc[AW+1:2]];
            ST_DECODE: begin
               rs1v <= regs[rs1];
               rs2v <= regs[rs2];
               imm  <= imm_nx;
            end
            ST_EXEC: begin
               alu_res <= alu_y;
               br_take <= br_cond;
            end
            ST_WB: begin
               if (wr_en) regs[rd] <= wb_val;
               pc <= pc_nx;
            end
         endcase
      end
   end

`ifdef CORE_TRACE_EN
   always_ff @(posedge clk) begin
      if (rst && pstage == ST_WB) begin
         if (wr_en)
            $display("TRACE pc=%h instr=%h rd=x%0d val=%h", pc, idata, rd, wb_val);
         else
            $display("TRACE pc=%h instr=%h rd=x%0d val=-", pc, idata, rd);
      end
   end
`endif
endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: directed scoreboard bench for rv32i_core.
module tb_rv32i_core;
   logic clk, rst;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } sb_t;

   sb_t         sbq[$];
   logic [31:0] pcq[$];
   logic [31:0] prog[$];
   logic [31:0] w0, w1;

   rv32i_core #(.MEM_WORDS(256), .MEM_INIT_FILE(""), .RESET_PC(32'h0)) dut (
      .clk(clk),
      .rst(rst)
   );

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] e_i(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [2:0] f3, input logic [4:0] rs1,
                                       input logic [11:0] imm);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] e_s(input logic [11:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] e_b(input logic [12:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] e_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_at(input string tag, input int sel, input logic [31:0] exp);
      sb_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sbq.push_back(e);
   endtask

   task automatic load_prog(input int hold);
      rst = 1'b0;
      for (int i = 0; i < 256; i++) dut.mem[i] = 32'd0;
      for (int i = 0; i < prog.size(); i++) dut.mem[i] = prog[i];
      prog.delete();
      repeat (hold) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic next_exec(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 16; n++) begin
         @(negedge clk);
         if (dut.pstage == 2'b10) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic run_obs(input int n);
      bit ok;
      int last;
      last = -1;
      for (int i = 0; i < n; i++) begin
         next_exec(ok);
         chk("exec_reached", {31'd0, ok}, 32'd1);
         if (!ok) break;
         if (last >= 0) chk("exec_period", cyc - last, 32'd4);
         last = cyc;
         if (pcq.size() > 0) chk("pc_trace", dut.pc, pcq.pop_front());
      end
   endtask

   task automatic drain_sb();
      sb_t e;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk(e.tag, e.sel < 32 ? dut.regs[e.sel] : dut.mem[e.sel - 32], e.exp);
      end
   endtask

   initial begin
      bit ok;
      logic [31:0] acc;
      rst = 1'b0;

      // reset and ADDI/ADD
      w0 = e_i(7'b0010011, 5'd1, 3'd0, 5'd0, 12'd5);
      prog.push_back(w0);
      prog.push_back(e_i(7'b0010011, 5'd2, 3'd0, 5'd0, 12'hFFD));
      prog.push_back(e_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd3));
      load_prog(3);
      #1;
      chk("reset_pc", dut.pc, 32'd0);
      chk("reset_pstage", {30'd0, dut.pstage}, 32'd0);
      chk("reset_idata", dut.idata, 32'd0);
      acc = 32'd0;
      for (int i = 0; i < 32; i++) acc = acc | dut.regs[i];
      chk("reset_regs_or", acc, 32'd0);
      next_exec(ok);
      chk("first_exec_reached", {31'd0, ok}, 32'd1);
      chk("first_idata", dut.idata, w0);
      chk("first_pc", dut.pc, 32'd0);
      pcq.push_back(32'd4); pcq.push_back(32'd8); pcq.push_back(32'd12);
      expect_at("addi_x1", 1, 32'd5);
      expect_at("addi_x2", 2, 32'hFFFF_FFFD);
      expect_at("add_x3", 3, 32'd2);
      run_obs(3);
      drain_sb();

      // LUI/SW/LB/LBU/LH/SB/LW
      prog.push_back({20'h80000, 5'd4, 7'b0110111});
      prog.push_back(e_i(7'b0010011, 5'd5, 3'd0, 5'd0, 12'h100));
      prog.push_back(e_s(12'd0, 5'd4, 5'd5, 3'd2));
      prog.push_back(e_i(7'b0000011, 5'd6, 3'd0, 5'd5, 12'd3));
      prog.push_back(e_i(7'b0000011, 5'd7, 3'd4, 5'd5, 12'd3));
      prog.push_back(e_i(7'b0000011, 5'd12, 3'd1, 5'd5, 12'd2));
      prog.push_back(e_i(7'b0010011, 5'd13, 3'd0, 5'd0, 12'h07F));
      prog.push_back(e_s(12'd1, 5'd13, 5'd5, 3'd0));
      prog.push_back(e_i(7'b0000011, 5'd14, 3'd2, 5'd5, 12'd0));
      load_prog(2);
      expect_at("lui_x4", 4, 32'h8000_0000);
      expect_at("lb_x6", 6, 32'hFFFF_FF80);
      expect_at("lbu_x7", 7, 32'h0000_0080);
      expect_at("lh_x12", 12, 32'hFFFF_8000);
      expect_at("lw_x14", 14, 32'h8000_7F00);
      expect_at("mem_0x100", 32 + 64, 32'h8000_7F00);
      run_obs(10);
      drain_sb();

      // branch loop and JAL
      prog.push_back(e_i(7'b0010011, 5'd1, 3'd0, 5'd0, 12'd3));
      prog.push_back(e_i(7'b0010011, 5'd1, 3'd0, 5'd1, 12'hFFF));
      prog.push_back(e_b(13'h1FFC, 5'd0, 5'd1, 3'd1));
      prog.push_back(e_j(21'd8, 5'd8));
      prog.push_back(e_i(7'b0010011, 5'd15, 3'd0, 5'd0, 12'd99));
      prog.push_back(e_i(7'b0010011, 5'd16, 3'd0, 5'd0, 12'd1));
      load_prog(2);
      foreach (pcq[i]) pcq.delete();
      pcq.push_back(32'd0);  pcq.push_back(32'd4);  pcq.push_back(32'd8);
      pcq.push_back(32'd4);  pcq.push_back(32'd8);  pcq.push_back(32'd4);
      pcq.push_back(32'd8);  pcq.push_back(32'd12); pcq.push_back(32'd20);
      pcq.push_back(32'd24);
      expect_at("loop_x1", 1, 32'd0);
      expect_at("jal_x8", 8, 32'd16);
      expect_at("skipped_x15", 15, 32'd0);
      expect_at("after_jal_x16", 16, 32'd1);
      run_obs(10);
      drain_sb();

      // x0, shifts, JALR
      prog.push_back(e_i(7'b0010011, 5'd0, 3'd0, 5'd0, 12'd7));
      w1 = e_i(7'b0010011, 5'd9, 3'd0, 5'd0, 12'hFF0);
      prog.push_back(w1);
      prog.push_back(e_i(7'b0010011, 5'd10, 3'd5, 5'd9, 12'h402));
      prog.push_back(e_i(7'b0010011, 5'd11, 3'd5, 5'd9, 12'd28));
      prog.push_back(e_i(7'b1100111, 5'd17, 3'd0, 5'd0, 12'd33));
      prog.push_back(e_i(7'b0010011, 5'd18, 3'd0, 5'd0, 12'd5));
      prog.push_back(32'd0); prog.push_back(32'd0);
      prog.push_back(e_i(7'b0010011, 5'd19, 3'd0, 5'd0, 12'd1));
      load_prog(2);
      pcq.push_back(32'd0);  pcq.push_back(32'd4);  pcq.push_back(32'd8);
      pcq.push_back(32'd12); pcq.push_back(32'd16); pcq.push_back(32'd32);
      pcq.push_back(32'd36);
      expect_at("x0_zero", 0, 32'd0);
      expect_at("addi_x9", 9, 32'hFFFF_FFF0);
      expect_at("srai_x10", 10, 32'hFFFF_FFFC);
      expect_at("srli_x11", 11, 32'h0000_000F);
      expect_at("jalr_x17", 17, 32'd20);
      expect_at("jalr_skip_x18", 18, 32'd0);
      expect_at("jalr_tgt_x19", 19, 32'd1);
      run_obs(7);
      drain_sb();

      // asynchronous reset between edges during EXECUTE
      next_exec(ok);
      chk("pre_async_exec", {31'd0, ok}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("async_pc", dut.pc, 32'd0);
      chk("async_pstage", {30'd0, dut.pstage}, 32'd0);
      chk("async_idata", dut.idata, 32'd0);
      chk("async_x9", dut.regs[9], 32'd0);
      chk("async_x19", dut.regs[19], 32'd0);
      chk("async_mem_kept", dut.mem[1], w1);
      @(negedge clk);
      rst = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
